// File: rtl/snn_img_loader.sv
// Image loader: collects NUM_BYTES UART bytes and unpacks each one LSB first into a 1-bit
// image RAM. It pulses img_rdy when the image is full. Define LOADER_TIMEOUT_EN to discard stale partial images.
module snn_img_loader #(
   parameter int NUM_BYTES   = 98,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 5_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   input  logic              core_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wdata,
   output logic              img_rdy,
   output logic              busy,
   output logic              ovf_err,
   output logic              tmo_err
);
   localparam int              BI_W      = ADDR_W - 3;
   localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NUM_BYTES - 1);
   localparam logic [22:0]     TMO_LAST  = 23'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {LOAD, SHIFT, DONE, WAIT_CORE} state_t;

   state_t          state_q, state_d;
   logic [BI_W-1:0] byte_idx_q, byte_idx_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      hold_q, hold_d;
   logic            hold_vld_q, hold_vld_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic            tmo_hit;

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LOAD;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
      end
   end

   // NOTE: every combinational target gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      busy_d     = busy_q;
      ovf_d      = ovf_q;
      case (state_q)
         LOAD: begin
            if (rx_rdy) begin
               shift_d   = rx_data;
               bit_idx_d = 3'd0;
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end else if (tmo_hit) begin
               byte_idx_d = '0;
               busy_d     = 1'b0;
            end
         end
         SHIFT: begin
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
               if (byte_idx_q == LAST_BYTE) begin
                  // Anything still pending belongs to no image: drop it.
                  state_d    = DONE;
                  hold_vld_d = 1'b0;
                  if (hold_vld_q || rx_rdy) ovf_d = 1'b1;
               end else begin
                  byte_idx_d = byte_idx_q + BI_W'(1);
                  if (hold_vld_q) begin
                     shift_d    = hold_q;
                     hold_vld_d = rx_rdy;
                     if (rx_rdy) hold_d = rx_data;
                  end else if (rx_rdy) begin
                     shift_d = rx_data;
                  end else begin
                     state_d = LOAD;
                  end
               end
            end else if (rx_rdy) begin
               if (hold_vld_q) begin
                  ovf_d = 1'b1;
               end else begin
                  hold_d     = rx_data;
                  hold_vld_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d    = WAIT_CORE;
            byte_idx_d = '0;
            if (rx_rdy) ovf_d = 1'b1;
         end
         WAIT_CORE: begin
            if (rx_rdy) ovf_d = 1'b1;
            if (core_done) begin
               state_d = LOAD;
               busy_d  = 1'b0;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // ram_we decodes straight from the state register, so reset drops it immediately.
   always_comb begin
      ram_we    = (state_q == SHIFT);
      img_rdy   = (state_q == DONE);
      ram_addr  = '0;
      ram_wdata = 1'b0;
      if (state_q == SHIFT) begin
         ram_addr  = {byte_idx_q, 3'b000} + ADDR_W'(bit_idx_q);
         ram_wdata = shift_q[bit_idx_q];
      end
   end

   assign busy    = busy_q;
   assign ovf_err = ovf_q;

`ifdef LOADER_TIMEOUT_EN
   logic [22:0] idle_cnt_q, idle_cnt_d;
   logic        tmo_q;
   logic        idle_run;

   assign idle_run = (state_q == LOAD) && (byte_idx_q != '0) && !hold_vld_q;
   assign tmo_hit  = idle_run && !rx_rdy && (idle_cnt_q == TMO_LAST);

   always_comb begin
      idle_cnt_d = '0;
      if (idle_run && !rx_rdy && !tmo_hit) idle_cnt_d = idle_cnt_q + 23'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q <= '0;
         tmo_q      <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         tmo_q      <= tmo_hit;
      end
   end

   assign tmo_err = tmo_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^TMO_LAST;
   assign tmo_hit    = 1'b0;
   assign tmo_err    = 1'b0;
`endif

endmodule

// File: tb/tb_snn_img_loader.sv
// Self-checking bench for snn_img_loader: random bytes against a timeline model of the
// expected pixel writes (one shifter, one pending byte).
module tb_snn_img_loader;
   localparam int NUM_BYTES = 98;
   localparam int ADDR_W    = 10;
   localparam int TMO       = 1000;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              rx_rdy    = 1'b0;
   logic [7:0]        rx_data   = 8'h00;
   logic              core_done = 1'b0;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wdata;
   logic              img_rdy;
   logic              busy;
   logic              ovf_err;
   logic              tmo_err;

   always #5 clk = ~clk;

   snn_img_loader #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .core_done(core_done),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .img_rdy(img_rdy),
      .busy(busy), .ovf_err(ovf_err), .tmo_err(tmo_err)
   );

   typedef struct packed {
      logic [31:0]       cyc;
      logic [ADDR_W-1:0] addr;
      logic              d;
   } wr_t;

   wr_t log_q[$];
   wr_t exp_q[$];
   int  rdy_log[$];
   int  exp_rdy[$];
   int  tmo_log[$];
   wr_t mon_w;
   int  cyc     = 0;
   int  n_pass  = 0;
   int  n_total = 0;
   int  m_pos;
   int  m_end;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_we) begin
            mon_w.cyc  = 32'(cyc);
            mon_w.addr = ram_addr;
            mon_w.d    = ram_wdata;
            log_q.push_back(mon_w);
         end
         if (img_rdy) rdy_log.push_back(cyc);
         if (tmo_err) tmo_log.push_back(cyc);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference model: a byte sampled in cycle t writes its 8 pixels in the 8 cycles
   // starting at max(t+1, end of previous byte + 1); pixel address = image position*8+bit.
   task automatic model_byte(input logic [7:0] b, input int t);
      int  s;
      wr_t e;
      s = (t + 1 > m_end + 1) ? t + 1 : m_end + 1;
      for (int i = 0; i < 8; i++) begin
         e.cyc  = 32'(s + i);
         e.addr = ADDR_W'(m_pos * 8 + i);
         e.d    = b[i];
         exp_q.push_back(e);
      end
      m_end = s + 7;
      m_pos++;
      if (m_pos == NUM_BYTES) begin
         exp_rdy.push_back(m_end + 1);
         m_pos = 0;
      end
   endtask

   task automatic clear_all();
      log_q.delete(); exp_q.delete(); rdy_log.delete(); exp_rdy.delete(); tmo_log.delete();
      m_pos = 0;
      m_end = -100;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, output int n);
      rx_data = b;
      rx_rdy  = 1'b1;
      n       = cyc;
      tick();
      rx_rdy  = 1'b0;
   endtask

   task automatic pulse_core_done();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; rx_rdy = 1'b0; core_done = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      clear_all();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_rdy = 1'b0; core_done = 1'b0; rx_data = 8'h00;
      tick(); tick();
      n_total++;
      if ({ram_we, ram_addr, ram_wdata, img_rdy, busy, ovf_err, tmo_err} !== '0)
         $display("FAIL reset_outputs: got we=%b addr=%0d wd=%b rdy=%b busy=%b ovf=%b tmo=%b, expected all 0",
                  ram_we, ram_addr, ram_wdata, img_rdy, busy, ovf_err, tmo_err);
      else n_pass++;
      rst_n = 1'b1;
      clear_all();
      repeat (100) tick();
      n_total++;
      if (log_q.size() !== 0) $display("FAIL idle_writes: got %0d writes, expected 0", log_q.size());
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL idle_busy: got %b, expected 0", busy);
      else n_pass++;
   endtask

   task automatic test_single_byte();
      int n;
      apply_reset();
      send_byte(8'hA5, n);
      model_byte(8'hA5, n);
      repeat (12) tick();
      n_total++;
      if (busy !== 1'b1) $display("FAIL single_busy: got %b, expected 1", busy);
      else n_pass++;
      n_total++;
      if (rdy_log.size() !== 0) $display("FAIL single_img_rdy: got %0d pulses, expected 0", rdy_log.size());
      else n_pass++;
      n_total++;
      if (log_q.size() !== exp_q.size()) $display("FAIL single_count: got %0d writes, expected %0d", log_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
         n_total++;
         if (log_q[i] !== exp_q[i])
            $display("FAIL single_wr[%0d]: got cyc %0d addr %0d d %b, expected cyc %0d addr %0d d %b",
                     i, log_q[i].cyc, log_q[i].addr, log_q[i].d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].d);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_shift();
      int         n;
      logic [7:0] b;
      apply_reset();
      b = 8'($urandom);
      send_byte(b, n);
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (ram_we !== 1'b0) $display("FAIL async_reset_we: got %b, expected 0", ram_we);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b, expected 0", busy);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      clear_all();
      b = 8'($urandom);
      send_byte(b, n);
      model_byte(b, n);
      repeat (12) tick();
      n_total++;
      if (log_q.size() !== exp_q.size()) $display("FAIL restart_count: got %0d writes, expected %0d", log_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
         n_total++;
         if (log_q[i] !== exp_q[i])
            $display("FAIL restart_wr[%0d]: got cyc %0d addr %0d d %b, expected cyc %0d addr %0d d %b",
                     i, log_q[i].cyc, log_q[i].addr, log_q[i].d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].d);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int         n;
      logic [7:0] b;
      apply_reset();
      b = 8'($urandom); send_byte(b, n); model_byte(b, n);
      repeat (2) tick();
      b = 8'($urandom); send_byte(b, n); model_byte(b, n);
      n_total++;
      if (ovf_err !== 1'b0) $display("FAIL b2b_ovf_early: got %b, expected 0", ovf_err);
      else n_pass++;
      b = 8'($urandom); send_byte(b, n);
      repeat (20) tick();
      n_total++;
      if (ovf_err !== 1'b1) $display("FAIL b2b_ovf: got %b, expected 1", ovf_err);
      else n_pass++;
      pulse_core_done();
      n_total++;
      if (busy !== 1'b1) $display("FAIL b2b_core_done_ignored: got busy %b, expected 1", busy);
      else n_pass++;
      b = 8'($urandom); send_byte(b, n); model_byte(b, n);
      repeat (12) tick();
      n_total++;
      if (log_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d writes, expected %0d", log_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
         n_total++;
         if (log_q[i] !== exp_q[i])
            $display("FAIL b2b_wr[%0d]: got cyc %0d addr %0d d %b, expected cyc %0d addr %0d d %b",
                     i, log_q[i].cyc, log_q[i].addr, log_q[i].d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].d);
         else n_pass++;
      end
   endtask

   task automatic test_full_image_ff();
      int n;
      apply_reset();
      for (int k = 0; k < NUM_BYTES; k++) begin
         send_byte(8'hFF, n);
         model_byte(8'hFF, n);
         repeat (433) tick();
      end
      n_total++;
      if (ovf_err !== 1'b0) $display("FAIL ff_ovf: got %b, expected 0", ovf_err);
      else n_pass++;
      n_total++;
      if (rdy_log.size() !== exp_rdy.size()) $display("FAIL ff_rdy_count: got %0d pulses, expected %0d", rdy_log.size(), exp_rdy.size());
      else n_pass++;
      foreach (exp_rdy[i]) if (i < rdy_log.size()) begin
         n_total++;
         if (rdy_log[i] !== exp_rdy[i]) $display("FAIL ff_rdy_cyc: got %0d, expected %0d", rdy_log[i], exp_rdy[i]);
         else n_pass++;
      end
      n_total++;
      if (log_q.size() !== exp_q.size()) $display("FAIL ff_count: got %0d writes, expected %0d", log_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
         n_total++;
         if (log_q[i] !== exp_q[i])
            $display("FAIL ff_wr[%0d]: got cyc %0d addr %0d d %b, expected cyc %0d addr %0d d %b",
                     i, log_q[i].cyc, log_q[i].addr, log_q[i].d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].d);
         else n_pass++;
      end
   endtask

   // Continues from the completed image of test_full_image_ff.
   task automatic test_wait_core();
      int         n;
      logic [7:0] b;
      log_q.delete(); exp_q.delete();
      send_byte(8'h01, n);
      repeat (12) tick();
      n_total++;
      if (log_q.size() !== 0) $display("FAIL wait_drop_writes: got %0d writes, expected 0", log_q.size());
      else n_pass++;
      n_total++;
      if (ovf_err !== 1'b1) $display("FAIL wait_ovf: got %b, expected 1", ovf_err);
      else n_pass++;
      n_total++;
      if (busy !== 1'b1) $display("FAIL wait_busy: got %b, expected 1", busy);
      else n_pass++;
      pulse_core_done();
      n_total++;
      if (busy !== 1'b0) $display("FAIL core_done_busy: got %b, expected 0", busy);
      else n_pass++;
      b = 8'($urandom);
      send_byte(b, n);
      model_byte(b, n);
      repeat (12) tick();
      n_total++;
      if (log_q.size() !== exp_q.size()) $display("FAIL rearm_count: got %0d writes, expected %0d", log_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
         n_total++;
         if (log_q[i] !== exp_q[i])
            $display("FAIL rearm_wr[%0d]: got cyc %0d addr %0d d %b, expected cyc %0d addr %0d d %b",
                     i, log_q[i].cyc, log_q[i].addr, log_q[i].d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].d);
         else n_pass++;
      end
   endtask

   // Short gaps land inside the previous byte's shift; each is followed by a long gap.
   task automatic test_random_image();
      int         n;
      int         gap;
      logic [7:0] b;
      apply_reset();
      for (int k = 0; k < NUM_BYTES; k++) begin
         b = 8'($urandom);
         send_byte(b, n);
         model_byte(b, n);
         gap = (k % 2 == 0) ? int'($urandom_range(7, 2)) : int'($urandom_range(24, 16));
         repeat (gap - 1) tick();
      end
      repeat (20) tick();
      n_total++;
      if (ovf_err !== 1'b0) $display("FAIL rnd_ovf: got %b, expected 0", ovf_err);
      else n_pass++;
      n_total++;
      if (rdy_log.size() !== exp_rdy.size()) $display("FAIL rnd_rdy_count: got %0d pulses, expected %0d", rdy_log.size(), exp_rdy.size());
      else n_pass++;
      foreach (exp_rdy[i]) if (i < rdy_log.size()) begin
         n_total++;
         if (rdy_log[i] !== exp_rdy[i]) $display("FAIL rnd_rdy_cyc: got %0d, expected %0d", rdy_log[i], exp_rdy[i]);
         else n_pass++;
      end
      n_total++;
      if (log_q.size() !== exp_q.size()) $display("FAIL rnd_count: got %0d writes, expected %0d", log_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
         n_total++;
         if (log_q[i] !== exp_q[i])
            $display("FAIL rnd_wr[%0d]: got cyc %0d addr %0d d %b, expected cyc %0d addr %0d d %b",
                     i, log_q[i].cyc, log_q[i].addr, log_q[i].d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].d);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      int         n;
      int         n3;
      logic [7:0] b;
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         b = 8'($urandom);
         send_byte(b, n);
         model_byte(b, n);
         repeat (19) tick();
      end
      n3 = n;
      repeat (900 - 19 - 1) tick();
      n_total++;
      if (tmo_log.size() !== 0) $display("FAIL tmo_early: got %0d pulse cycles, expected 0", tmo_log.size());
      else n_pass++;
`ifdef LOADER_TIMEOUT_EN
      repeat (200) tick();
      n_total++;
      if (tmo_log.size() !== 1) $display("FAIL tmo_pulse: got %0d pulse cycles, expected 1", tmo_log.size());
      else n_pass++;
      if (tmo_log.size() > 0) begin
         n_total++;
         if (tmo_log[0] < n3 + TMO || tmo_log[0] > n3 + TMO + 12)
            $display("FAIL tmo_cyc: got %0d, expected in %0d..%0d", tmo_log[0], n3 + TMO, n3 + TMO + 12);
         else n_pass++;
      end
      n_total++;
      if (busy !== 1'b0) $display("FAIL tmo_busy: got %b, expected 0", busy);
      else n_pass++;
      m_pos = 0;
`else
      repeat (600) tick();
      n_total++;
      if (tmo_log.size() !== 0) $display("FAIL no_tmo_pulse: got %0d pulse cycles, expected 0 (n3=%0d)", tmo_log.size(), n3);
      else n_pass++;
      n_total++;
      if (busy !== 1'b1) $display("FAIL no_tmo_busy: got %b, expected 1", busy);
      else n_pass++;
`endif
      b = 8'($urandom);
      send_byte(b, n);
      model_byte(b, n);
      repeat (12) tick();
      n_total++;
      if (log_q.size() !== exp_q.size()) $display("FAIL tmo_count: got %0d writes, expected %0d", log_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < log_q.size()) begin
         n_total++;
         if (log_q[i] !== exp_q[i])
            $display("FAIL tmo_wr[%0d]: got cyc %0d addr %0d d %b, expected cyc %0d addr %0d d %b",
                     i, log_q[i].cyc, log_q[i].addr, log_q[i].d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].d);
         else n_pass++;
      end
   endtask

   initial begin
      clear_all();
      test_reset();
      test_single_byte();
      test_reset_mid_shift();
      test_back_to_back();
      test_full_image_ff();
      test_wait_core();
      test_random_image();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
